// File: rtl/time_keeper.sv
// BCD time-of-day counter with a button-driven set mode feeding the seven-segment scan mux.
// Define TK_12H_EN for 12-hour display (12,01..11 with pm); default build is 24-hour.
module time_keeper (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       blink_en,
    output logic [1:0] blink_sel
);

    // State encodings double as the blink field select the multiplexer consumes.
    localparam logic [1:0] ST_HH  = 2'b00;
    localparam logic [1:0] ST_MM  = 2'b01;
    localparam logic [1:0] ST_SS  = 2'b10;
    localparam logic [1:0] ST_RUN = 2'b11;

`ifdef TK_12H_EN
    localparam logic [7:0] HH_RST = 8'h12;
`else
    localparam logic [7:0] HH_RST = 8'h00;
`endif

    logic [1:0] state_q, state_d;
    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       pm_q, pm_d;
    logic       phase_q, phase_d;
    logic       blink_en_q, blink_en_d;

    // Two-digit BCD increment that wraps to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] v);
`ifdef TK_12H_EN
        return (v == 8'h12) ? 8'h01 : bcd_inc(v, 8'h12);
`else
        return bcd_inc(v, 8'h23);
`endif
    endfunction

    function automatic logic pm_next(input logic [7:0] v, input logic p);
`ifdef TK_12H_EN
        return (v == 8'h11) ? ~p : p;
`else
        return p & (v == 8'hFF);
`endif
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        pm_d    = pm_q;

        case (state_q)
            ST_RUN: begin
                if (tick_1hz) begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd_inc(mm_q, 8'h59);
                        if (mm_q == 8'h59) begin
                            hh_d = hour_inc(hh_q);
                            pm_d = pm_next(hh_q, pm_q);
                        end
                    end
                end
                if (btn_mode)
                    state_d = ST_HH;
            end
            ST_HH: begin
                if (btn_mode) begin
                    state_d = ST_MM;
                end else if (btn_inc) begin
                    hh_d = hour_inc(hh_q);
                    pm_d = pm_next(hh_q, pm_q);
                end
            end
            ST_MM: begin
                if (btn_mode)
                    state_d = ST_SS;
                else if (btn_inc)
                    mm_d = bcd_inc(mm_q, 8'h59);
            end
            default: begin
                if (btn_mode)
                    state_d = ST_RUN;
                else if (btn_inc)
                    ss_d = bcd_inc(ss_q, 8'h59);
            end
        endcase

        // A press always shows the field immediately, overriding a coincident 2 Hz toggle.
        if (btn_mode || btn_inc)
            phase_d = 1'b0;
        else if (tick_2hz)
            phase_d = ~phase_q;
        else
            phase_d = phase_q;

        blink_en_d = phase_d && (state_d != ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            hh_q       <= HH_RST;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            pm_q       <= 1'b0;
            phase_q    <= 1'b0;
            blink_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            pm_q       <= pm_d;
            phase_q    <= phase_d;
            blink_en_q <= blink_en_d;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign pm        = pm_q;
    assign blink_en  = blink_en_q;
    assign blink_sel = state_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus randomized traffic
// compared against a seconds/fields reference model (24-hour or 12-hour display per TK_12H_EN).
module tb_time_keeper;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       blink_en;
    logic [1:0] blink_sel;

    int n_total;
    int n_pass;

    // Reference model: hour kept as 0..23 regardless of display mode, mode as 0=RUN,1=HH,2=MM,3=SS.
    int m_h, m_m, m_s, m_st;
    bit m_phase;

    time_keeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .pm        (pm),
        .blink_en  (blink_en),
        .blink_sel (blink_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [7:0] eh;
        logic       epm;
        logic [1:0] esel;
`ifdef TK_12H_EN
        eh  = to_bcd((m_h % 12 == 0) ? 12 : m_h % 12);
        epm = (m_h >= 12);
`else
        eh  = to_bcd(m_h);
        epm = 1'b0;
`endif
        esel = (m_st == 0) ? 2'b11 : 2'(m_st - 1);
        return {eh, to_bcd(m_m), to_bcd(m_s), epm, m_phase && (m_st != 0), esel};
    endfunction

    function automatic logic [27:0] got_vec();
        return {hh, mm, ss, pm, blink_en, blink_sel};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_phase = 1'b0;
    endtask

    task automatic model_step(input bit md, input bit ic, input bit t1, input bit t2);
        if (m_st == 0 && t1) begin
            int tod;
            tod = ((m_h * 3600 + m_m * 60 + m_s) + 1) % 86400;
            m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
        end else if (m_st != 0 && ic && !md) begin
            if (m_st == 1) m_h = (m_h + 1) % 24;
            if (m_st == 2) m_m = (m_m + 1) % 60;
            if (m_st == 3) m_s = (m_s + 1) % 60;
        end
        if (md) m_st = (m_st + 1) % 4;
        if (md || ic) m_phase = 1'b0;
        else if (t2) m_phase = ~m_phase;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input bit md, input bit ic, input bit t1, input bit t2);
        btn_mode = md; btn_inc = ic; tick_1hz = t1; tick_2hz = t2;
        @(posedge clk);
        model_step(md, ic, t1, t2);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
    endtask

    // Enter set mode and dial in a target time, then return to RUN.
    task automatic preload(input int th, input int tm, input int ts);
        int n;
        cycle(1, 0, 0, 0);
        n = (th - m_h + 24) % 24;
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        n = (tm - m_m + 60) % 60;
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        n = (ts - m_s + 60) % 60;
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #5;
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL reset_state: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL reset_release: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_count();
        for (int i = 0; i < 3661; i++) begin
            cycle(0, 0, 1, ($urandom % 3) == 0);
            if (($urandom % 4) == 0) cycle(0, 0, 0, 0);
        end
        n_total++;
        if ({hh, mm, ss, blink_sel, blink_en} !== {8'h01, 8'h01, 8'h01, 2'b11, 1'b0})
            $display("FAIL count_3661: got %h:%h:%h sel=%b en=%b expected 01:01:01 sel=11 en=0",
                     hh, mm, ss, blink_sel, blink_en);
        else n_pass++;
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL count_model: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_rollover();
        preload(23, 59, 58);
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL preload_235958: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        cycle(0, 0, 1, 0);
        n_total++;
        if (got_vec() !== exp_vec() || ss !== 8'h59)
            $display("FAIL roll_235959: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        cycle(0, 0, 1, 0);
        n_total++;
        if (got_vec() !== exp_vec() || {mm, ss} !== 16'h0000)
            $display("FAIL roll_000000: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_set_hh();
        logic [7:0] mm_keep, ss_keep;
        mm_keep = to_bcd(m_m);
        ss_keep = to_bcd(m_s);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 25; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        n_total++;
        if (hh !== 8'h01 || mm !== mm_keep || ss !== ss_keep || blink_sel !== 2'b00)
            $display("FAIL set_hh_wrap: got %h:%h:%h sel=%b expected 01:%h:%h sel=00",
                     hh, mm, ss, blink_sel, mm_keep, ss_keep);
        else n_pass++;
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL set_hh_model: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_blink();
        cycle(1, 0, 0, 0);
        n_total++;
        if (blink_sel !== 2'b01 || blink_en !== 1'b0)
            $display("FAIL blink_enter_mm: got sel=%b en=%b expected sel=01 en=0", blink_sel, blink_en);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1);
            n_total++;
            if (blink_en !== ((i % 2) == 0))
                $display("FAIL blink_toggle_%0d: got en=%b expected %b", i, blink_en, (i % 2) == 0);
            else n_pass++;
            cycle(0, 0, 0, 0);
        end
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        n_total++;
        if (blink_en !== 1'b0 || got_vec() !== exp_vec())
            $display("FAIL blink_inc_clear: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        n_total++;
        if (blink_en !== 1'b0)
            $display("FAIL blink_press_vs_2hz: got en=%b expected 0", blink_en);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] hh_keep, ss_next, ss_keep;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        hh_keep = hh;
        cycle(1, 1, 0, 0);
        n_total++;
        if (blink_sel !== 2'b01 || hh !== hh_keep || got_vec() !== exp_vec())
            $display("FAIL mode_and_inc: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        ss_keep = ss;
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        n_total++;
        if (blink_sel !== 2'b11 || ss !== ss_keep || got_vec() !== exp_vec())
            $display("FAIL mode_tick_set_ss: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        ss_next = to_bcd((m_s + 1) % 60);
        cycle(1, 0, 1, 0);
        n_total++;
        if (blink_sel !== 2'b00 || ss !== ss_next || got_vec() !== exp_vec())
            $display("FAIL mode_tick_run: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid_set();
        cycle(0, 1, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        n_total++;
        if (got_vec() !== exp_vec())
            $display("FAIL reset_mid_set: got %h expected %h", got_vec(), exp_vec());
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 12) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0);
            n_total++;
            if (got_vec() !== exp_vec()) begin
                if (errs < 10)
                    $display("FAIL random_%0d: got %h expected %h", i, got_vec(), exp_vec());
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_count();
        test_rollover();
        test_set_hh();
        test_blink();
        test_simultaneous();
        test_reset_mid_set();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
